core_host_ctrl: RTL and testbench
=================================

// Module: core_host_ctrl
// PURPOSE
//  Host-side counterpart to the CPU's req/done interface. Preloads operands into data memory
//  while holding the core in reset, then releases the core and waits for its done flag.
//  Afterwards it streams a result window out of data memory over a valid/ready port.
//  Sits beside top_level and owns the dat_mem port whenever the core is not running.
// PARAMETERS
//  AW        8     data-memory address width
//  DW        8     data-memory word width
//  LOAD_BASE 0     first dmem address written in LOAD
//  LOAD_LEN  64    words accepted in LOAD (0 = skip LOAD)
//  RES_BASE  64    first dmem address read in DRAIN
//  RES_LEN   64    words emitted in DRAIN (0 = skip DRAIN)
//  TIMEOUT   4096  maximum RUN cycles before forced abort (>=2)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   job request, sampled only in IDLE
//  ld_valid     in   1   operand word valid
//  ld_data      in   DW  operand word
//  ld_ready     out  1   controller accepts operand
//  mem_sel      out  1   1 = host drives dmem port, 0 = core drives it
//  mem_wr_en    out  1   dmem write strobe
//  mem_addr     out  AW  dmem address
//  mem_wr_data  out  DW  dmem write data (= ld_data)
//  mem_rd_data  in   DW  dmem read data, combinational from mem_addr
//  core_rst     out  1   active-high reset to the core
//  core_req     out  1   core-run request, high throughout RUN
//  core_done    in   1   core completion flag (level)
//  res_valid    out  1   result word valid
//  res_data     out  DW  result word
//  res_ready    in   1   consumer accepts result
//  busy         out  1   state != IDLE
//  timeout      out  1   sticky: last job hit TIMEOUT
//  job_done     out  1   one-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset (reset=0, any time, mid-job too): state=IDLE, counters=0, timeout=0. Outputs:
//   core_rst=1, mem_sel=1, all other outputs 0. No partial transfer resumes afterward.
//  FSM states are IDLE -> LOAD -> RUN -> DRAIN -> IDLE.
//  IDLE: core_rst=1, mem_sel=1, ld_ready=0, res_valid=0.
//   start=1 clears timeout and cnt. Next state is LOAD, or RUN if LOAD_LEN=0.
//   start is ignored in every other state.
//  LOAD: ld_ready=1, mem_addr=(LOAD_BASE+cnt) mod 2^AW.
//   mem_wr_en = ld_valid & ld_ready, so the write happens in the handshake cycle.
//   Each handshake increments cnt. The handshake with cnt=LOAD_LEN-1 moves to RUN and clears
//   cnt and cyc. ld_valid=0 stalls indefinitely.
//  RUN: mem_sel=0, core_rst=0, core_req=1. mem_wr_en=0 and ld_ready=0. cyc increments.
//   core_done is ignored in the first RUN cycle (core still leaving reset).
//   core_done=1 on a later cycle moves to DRAIN.
//   If cyc=TIMEOUT-1 without done, timeout<=1 and the state moves to DRAIN.
//   If done and timeout coincide, done wins and timeout stays 0.
//   core_rst reasserts on the first DRAIN cycle.
//  DRAIN: mem_sel=1, mem_addr=(RES_BASE+cnt) mod 2^AW, res_valid=1, res_data=mem_rd_data.
//   res_data is stable while stalled because mem_addr holds.
//   Each res_valid & res_ready handshake increments cnt.
//   The handshake at cnt=RES_LEN-1 moves to IDLE and sets job_done=1 for that next cycle.
//   If RES_LEN=0, DRAIN lasts one cycle with res_valid=0, then goes to IDLE with job_done.
//  Widths: cnt and cyc are sized to hold LOAD_LEN/RES_LEN and TIMEOUT. Address adds wrap.
// TESTING
//  Reset: hold reset=0 mid-LOAD after 10 words, release -> IDLE, busy=0, core_rst=1, no further mem_wr_en.
//  Full job: LOAD_LEN=4, data 11,22,33,44 -> dmem[0..3]. Core stub raises done 20 cycles later.
//   Then res_data = dmem[64..67] in order, job_done=1 exactly once, timeout=0.
//  Backpressure: ld_valid toggles and res_ready=0 for 5 cycles -> no duplicate or lost words.
//   res_data is held constant while stalled.
//  Timeout: TIMEOUT=16, core_done never set -> DRAIN entered after 16 RUN cycles, timeout=1.
//   timeout clears on the next start.
//  Edge: LOAD_LEN=0, RES_LEN=0 -> IDLE->RUN->DRAIN->IDLE. Also start pulsed in RUN is ignored.
//   Also core_done=1 in the first RUN cycle is ignored.
//  Wrap: LOAD_BASE=254, LOAD_LEN=4, AW=8 -> writes to addresses 254, 255, 0, 1.

Source files
------------

// File: rtl/core_host_ctrl_if.sv
// Host controller bus: operand load port, data-memory port, core control,
// result stream and status. The controller side uses the master modport.
interface core_host_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          core_rst;
    logic          core_req;
    logic          core_done;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          timeout;
    logic          job_done;

    modport master (
        input  start, ld_valid, ld_data, mem_rd_data, core_done, res_ready,
        output ld_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
               core_rst, core_req, res_valid, res_data, busy, timeout, job_done
    );

    modport slave (
        output start, ld_valid, ld_data, mem_rd_data, core_done, res_ready,
        input  ld_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
               core_rst, core_req, res_valid, res_data, busy, timeout, job_done
    );
endinterface

// File: rtl/core_host_ctrl.sv
// Host-side job controller: preloads operands into dmem with the core held in
// reset, runs the core until done (or timeout), then streams a result window out.
module core_host_ctrl #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RES_BASE  = 64,
    parameter int RES_LEN   = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    core_host_ctrl_if.master bus
);
    localparam int CMAX = (LOAD_LEN > RES_LEN) ? LOAD_LEN : RES_LEN;
    // +2 keeps the width at least one bit even when both lengths are zero
    localparam int CW   = $clog2(CMAX + 2);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LOAD_LAST = CW'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
    localparam logic [CW-1:0] RES_LAST  = CW'((RES_LEN > 0) ? RES_LEN - 1 : 0);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] cyc;
    logic          timeout_q;
    logic          job_done_q;

    // Output decode: host owns dmem and holds the core in reset except in RUN
    always_comb begin
        bus.mem_sel   = 1'b1;
        bus.core_rst  = 1'b1;
        bus.core_req  = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.res_valid = 1'b0;
        case (state)
            S_LOAD: begin
                bus.ld_ready  = 1'b1;
                bus.mem_wr_en = bus.ld_valid;
                bus.mem_addr  = AW'(LOAD_BASE) + AW'(cnt);
            end
            S_RUN: begin
                bus.mem_sel  = 1'b0;
                bus.core_rst = 1'b0;
                bus.core_req = 1'b1;
            end
            S_DRAIN: begin
                bus.mem_addr  = AW'(RES_BASE) + AW'(cnt);
                bus.res_valid = (RES_LEN != 0);
            end
            default: ;
        endcase
    end

    // Data outputs are zeroed outside their phases so reset/idle reads all-zero
    assign bus.mem_wr_data = bus.ld_ready  ? bus.ld_data     : '0;
    assign bus.res_data    = bus.res_valid ? bus.mem_rd_data : '0;
    assign bus.busy        = (state != S_IDLE);
    assign bus.timeout     = timeout_q;
    assign bus.job_done    = job_done_q;

    // Job sequencing: IDLE -> LOAD -> RUN -> DRAIN -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cyc        <= '0;
            timeout_q  <= 1'b0;
            job_done_q <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        timeout_q <= 1'b0;
                        cnt       <= '0;
                        cyc       <= '0;
                        state     <= (LOAD_LEN == 0) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        if (cnt == LOAD_LAST) begin
                            state <= S_RUN;
                            cnt   <= '0;
                            cyc   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cyc <= cyc + 1'b1;
                    // done is ignored on cyc 0 while the core leaves reset;
                    // checked first so it beats a same-cycle timeout
                    if (cyc != '0 && bus.core_done) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else if (cyc == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_DRAIN;
                        cnt       <= '0;
                    end
                end
                S_DRAIN: begin
                    if (RES_LEN == 0 || (bus.res_ready && cnt == RES_LAST)) begin
                        state      <= S_IDLE;
                        job_done_q <= 1'b1;
                    end else if (bus.res_ready) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_host_ctrl.sv
// Bench for core_host_ctrl: three parameterisations share one stimulus stream,
// with sel choosing which one receives start/done and is observed.
module tb_core_host_ctrl;
    logic clk;
    logic reset;
    logic [1:0] sel;
    logic start_drv, done_drv, ld_valid, res_ready;
    logic [7:0] ld_data;

    core_host_ctrl_if #(.AW(8), .DW(8)) ifa ();
    core_host_ctrl_if #(.AW(8), .DW(8)) ifb ();
    core_host_ctrl_if #(.AW(8), .DW(8)) ifc ();

    core_host_ctrl #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(16), .RES_BASE(64),
                     .RES_LEN(8), .TIMEOUT(64)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    core_host_ctrl #(.AW(8), .DW(8), .LOAD_BASE(254), .LOAD_LEN(4), .RES_BASE(64),
                     .RES_LEN(4), .TIMEOUT(16)) u_b (.clk(clk), .reset(reset), .bus(ifb));
    core_host_ctrl #(.AW(8), .DW(8), .LOAD_BASE(0), .LOAD_LEN(0), .RES_BASE(64),
                     .RES_LEN(0), .TIMEOUT(8)) u_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [7:0] mem [256];

    assign ifa.start = start_drv && sel == 2'd0;
    assign ifb.start = start_drv && sel == 2'd1;
    assign ifc.start = start_drv && sel == 2'd2;
    assign ifa.core_done = done_drv && sel == 2'd0;
    assign ifb.core_done = done_drv && sel == 2'd1;
    assign ifc.core_done = done_drv && sel == 2'd2;
    assign ifa.ld_valid = ld_valid;  assign ifb.ld_valid = ld_valid;  assign ifc.ld_valid = ld_valid;
    assign ifa.ld_data  = ld_data;   assign ifb.ld_data  = ld_data;   assign ifc.ld_data  = ld_data;
    assign ifa.res_ready = res_ready; assign ifb.res_ready = res_ready; assign ifc.res_ready = res_ready;
    assign ifa.mem_rd_data = mem[ifa.mem_addr];
    assign ifb.mem_rd_data = mem[ifb.mem_addr];
    assign ifc.mem_rd_data = mem[ifc.mem_addr];

    // observed signals of the selected instance
    logic       ld_ready_s, mem_sel_s, mem_wr_en_s, core_rst_s, core_req_s;
    logic       res_valid_s, busy_s, timeout_s, job_done_s;
    logic [7:0] mem_addr_s, mem_wr_data_s, res_data_s;
    int         lb_s;

    // Observation mux for the instance under test
    always_comb begin
        {ld_ready_s, mem_sel_s, mem_wr_en_s, core_rst_s, core_req_s} = '0;
        {res_valid_s, busy_s, timeout_s, job_done_s} = '0;
        {mem_addr_s, mem_wr_data_s, res_data_s} = '0;
        lb_s = 0;
        case (sel)
            2'd0: begin
                {ld_ready_s, mem_sel_s, mem_wr_en_s, core_rst_s, core_req_s} =
                    {ifa.ld_ready, ifa.mem_sel, ifa.mem_wr_en, ifa.core_rst, ifa.core_req};
                {res_valid_s, busy_s, timeout_s, job_done_s} =
                    {ifa.res_valid, ifa.busy, ifa.timeout, ifa.job_done};
                {mem_addr_s, mem_wr_data_s, res_data_s} = {ifa.mem_addr, ifa.mem_wr_data, ifa.res_data};
            end
            2'd1: begin
                {ld_ready_s, mem_sel_s, mem_wr_en_s, core_rst_s, core_req_s} =
                    {ifb.ld_ready, ifb.mem_sel, ifb.mem_wr_en, ifb.core_rst, ifb.core_req};
                {res_valid_s, busy_s, timeout_s, job_done_s} =
                    {ifb.res_valid, ifb.busy, ifb.timeout, ifb.job_done};
                {mem_addr_s, mem_wr_data_s, res_data_s} = {ifb.mem_addr, ifb.mem_wr_data, ifb.res_data};
                lb_s = 254;
            end
            default: begin
                {ld_ready_s, mem_sel_s, mem_wr_en_s, core_rst_s, core_req_s} =
                    {ifc.ld_ready, ifc.mem_sel, ifc.mem_wr_en, ifc.core_rst, ifc.core_req};
                {res_valid_s, busy_s, timeout_s, job_done_s} =
                    {ifc.res_valid, ifc.busy, ifc.timeout, ifc.job_done};
                {mem_addr_s, mem_wr_data_s, res_data_s} = {ifc.mem_addr, ifc.mem_wr_data, ifc.res_data};
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem plus a stand-in core: while running, result[i] = operand[i] ^ 0xA5
    always @(posedge clk) begin
        if (mem_wr_en_s) mem[mem_addr_s] <= mem_wr_data_s;
        if (core_req_s)
            for (int i = 0; i < 8; i++) mem[8'(64 + i)] <= mem[8'(lb_s + i)] ^ 8'hA5;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  exp_ld[$];
    int n_jd = 0, n_run = 0, n_busy = 0;
    logic stall_q = 1'b0;
    logic [7:0] hold_q = '0;

    // Mid-cycle monitor: records writes, result handshakes, pulses, stall stability
    always @(negedge clk) begin
        if (mem_wr_en_s) wq.push_back({mem_addr_s, mem_wr_data_s});
        if (res_valid_s && res_ready) rq.push_back(res_data_s);
        if (job_done_s) n_jd <= n_jd + 1;
        if (core_req_s) n_run <= n_run + 1;
        if (busy_s) n_busy <= n_busy + 1;
        if (res_valid_s && stall_q) chk("stall_hold", res_data_s, hold_q);
        stall_q <= res_valid_s && !res_ready;
        hold_q  <= res_data_s;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_start;
        start_drv = 1'b1; tick(); start_drv = 1'b0;
    endtask

    task automatic run_load(input int n);
        int k = 0, g = 0;
        while (k < n && g < 400) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = 8'($urandom);
            @(negedge clk);
            if (ld_valid && ld_ready_s) begin exp_ld.push_back(ld_data); k++; end
            @(posedge clk); #1; g++;
        end
        ld_valid = 1'b0;
        if (k < n) chk("load_bound", k, n);
    endtask

    task automatic run_core(input int done_at, input bit first_only, input int start_at);
        int r = 1, g = 0;
        while (!core_req_s && g < 50) begin tick(); g++; end
        if (!core_req_s) begin chk("run_enter", 0, 1); return; end
        chk("run_mem_sel", mem_sel_s, 0);
        chk("run_core_rst", core_rst_s, 0);
        while (core_req_s && r < 5000) begin
            done_drv  = (r == done_at) || (first_only && r == 1);
            start_drv = (r == start_at);
            tick(); r++;
        end
        done_drv = 1'b0; start_drv = 1'b0;
        chk("drain_core_rst", core_rst_s, 1);
        chk("drain_mem_sel", mem_sel_s, 1);
    endtask

    task automatic run_drain(input int n, input int stall);
        int k = 0, g = 0, s = stall;
        while (k < n && g < 600) begin
            res_ready = (s > 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (res_valid_s && res_ready) k++;
            if (res_valid_s && s > 0) s--;
            @(posedge clk); #1; g++;
        end
        res_ready = 1'b0;
        if (k < n) chk("drain_bound", k, n);
    endtask

    // One job end to end, checked against the expected write/result streams
    task automatic job(input int ll, input int rl, input int lb, input int done_at,
                       input bit first_only, input int start_at, input int stall,
                       input int exp_run, input int exp_to, input int exp_busy);
        int w0, r0, j0, run0, b0, g;
        exp_ld.delete();
        w0 = wq.size(); r0 = rq.size(); j0 = n_jd; run0 = n_run; b0 = n_busy;
        do_start();
        chk("timeout_clr", timeout_s, 0);
        run_load(ll);
        run_core(done_at, first_only, start_at);
        run_drain(rl, stall);
        g = 0;
        while (n_jd == j0 && g < 20) begin tick(); g++; end
        repeat (5) tick();
        chk("wr_cnt", wq.size() - w0, ll);
        for (int i = 0; i < ll && w0 + i < wq.size() && i < exp_ld.size(); i++) begin
            chk("wr_addr", wq[w0 + i][15:8], (lb + i) % 256);
            chk("wr_data", wq[w0 + i][7:0], exp_ld[i]);
        end
        chk("res_cnt", rq.size() - r0, rl);
        for (int i = 0; i < rl && r0 + i < rq.size() && i < exp_ld.size(); i++)
            chk("res_data", rq[r0 + i], exp_ld[i] ^ 8'hA5);
        chk("job_done_cnt", n_jd - j0, 1);
        chk("run_len", n_run - run0, exp_run);
        chk("timeout", timeout_s, exp_to);
        chk("idle_busy", busy_s, 0);
        if (exp_busy >= 0) chk("busy_len", n_busy - b0, exp_busy);
    endtask

    initial begin
        int w0;
        sel = 2'd0; reset = 1'b0; start_drv = 1'b0; done_drv = 1'b0;
        ld_valid = 1'b0; ld_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_s, 0);
        chk("rst_core_rst", core_rst_s, 1);
        chk("rst_mem_sel", mem_sel_s, 1);
        chk("rst_outs", {ld_ready_s, mem_wr_en_s, core_req_s, res_valid_s, timeout_s, job_done_s}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // reset in the middle of LOAD abandons the job
        do_start();
        run_load(10);
        chk("abort_wr_cnt", exp_ld.size(), 10);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy_s, 0);
        chk("abort_core_rst", core_rst_s, 1);
        chk("abort_ld_ready", ld_ready_s, 0);
        tick(); tick();
        reset = 1'b1;
        w0 = wq.size();
        ld_valid = 1'b1;
        repeat (5) tick();
        ld_valid = 1'b0;
        chk("abort_no_wr", wq.size() - w0, 0);
        chk("abort_idle", busy_s, 0);

        // full jobs with backpressure; done raised on RUN cycle 21
        for (int j = 0; j < 2; j++) job(16, 8, 0, 21, 1'b0, 0, 5, 21, 0, -1);

        // wrapped load, timeout, then done coinciding with the timeout cycle
        sel = 2'd1;
        job(4, 4, 254, 0, 1'b0, 0, 2, 16, 1, -1);
        chk("timeout_sticky", timeout_s, 1);
        job(4, 4, 254, 16, 1'b0, 0, 0, 16, 0, -1);

        // no load, no drain; done in first RUN cycle and start in RUN ignored
        sel = 2'd2;
        job(0, 0, 0, 0, 1'b1, 3, 0, 8, 1, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit");
    end
endmodule
